// File: rtl/tawas_dbus_arb_pkg.sv
// Shared tawas data-bus arbiter definitions: FSM state encoding and the
// default starvation threshold.
package tawas_dbus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [3:0] STARVE_LIMIT_DEF = 4'd15;

endpackage

// File: rtl/tawas_dbus_arb_if.sv
// Data-bus bundle between the core, the external requester, the memory and
// the arbiter. The arbiter uses the slave view, the surrounding system the master view.
interface tawas_dbus_arb_if;
    import tawas_dbus_arb_pkg::*;

    logic        CORE_DCS;
    logic        CORE_DWR;
    logic [31:0] CORE_DADDR;
    logic [3:0]  CORE_DMASK;
    logic [31:0] CORE_DOUT;
    logic [31:0] CORE_DIN;

    logic        EXT_REQ;
    logic        EXT_WR;
    logic [31:0] EXT_ADDR;
    logic [3:0]  EXT_MASK;
    logic [1:0]  EXT_LEN;
    logic [31:0] EXT_WDATA;
    logic        EXT_ACK;
    logic        EXT_BEAT;
    logic        EXT_RVLD;
    logic [31:0] EXT_RDATA;
    logic        EXT_DONE;
    logic        STARVE;

    logic        MEM_CS;
    logic        MEM_WR;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_MASK;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    modport slave (
        input  CORE_DCS, CORE_DWR, CORE_DADDR, CORE_DMASK, CORE_DOUT,
        input  EXT_REQ, EXT_WR, EXT_ADDR, EXT_MASK, EXT_LEN, EXT_WDATA,
        input  MEM_RDATA,
        output CORE_DIN,
        output EXT_ACK, EXT_BEAT, EXT_RVLD, EXT_RDATA, EXT_DONE, STARVE,
        output MEM_CS, MEM_WR, MEM_ADDR, MEM_MASK, MEM_WDATA
    );

    modport master (
        output CORE_DCS, CORE_DWR, CORE_DADDR, CORE_DMASK, CORE_DOUT,
        output EXT_REQ, EXT_WR, EXT_ADDR, EXT_MASK, EXT_LEN, EXT_WDATA,
        output MEM_RDATA,
        input  CORE_DIN,
        input  EXT_ACK, EXT_BEAT, EXT_RVLD, EXT_RDATA, EXT_DONE, STARVE,
        input  MEM_CS, MEM_WR, MEM_ADDR, MEM_MASK, MEM_WDATA
    );

endinterface

// File: rtl/tawas_dbus_arb.sv
// Single-port data memory arbiter: the core always wins, a secondary requester
// runs word-aligned bursts of up to four beats in the cycles the core leaves free.
module tawas_dbus_arb
    import tawas_dbus_arb_pkg::*;
#(
    parameter logic [3:0] STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic             CLK,
    input logic             RST_N,
    tawas_dbus_arb_if.slave bus
);

    arb_state_e  state;
    logic        wr_q;
    logic [29:0] waddr_q;
    logic [3:0]  mask_q;
    logic [1:0]  cnt_q;
    logic        ack_q;
    logic        rvld_q;
    logic        done_q;
    logic        starve_q;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;
    logic        beat;

    assign beat = (state == BUSY) && !bus.CORE_DCS;

    assign bus.CORE_DIN  = bus.MEM_RDATA;
    assign bus.EXT_RDATA = bus.MEM_RDATA;
    assign bus.EXT_BEAT  = beat;
    assign bus.EXT_ACK   = ack_q;
    assign bus.EXT_RVLD  = rvld_q;
    assign bus.EXT_DONE  = done_q;
    assign bus.STARVE    = starve_q;

    // Core traffic passes straight through; a burst beat only fills idle slots.
    always_comb begin
        bus.MEM_CS    = 1'b0;
        bus.MEM_WR    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_MASK  = '0;
        bus.MEM_WDATA = '0;
        if (bus.CORE_DCS) begin
            bus.MEM_CS    = 1'b1;
            bus.MEM_WR    = bus.CORE_DWR;
            bus.MEM_ADDR  = bus.CORE_DADDR;
            bus.MEM_MASK  = bus.CORE_DMASK;
            bus.MEM_WDATA = bus.CORE_DOUT;
        end else if (beat) begin
            bus.MEM_CS    = 1'b1;
            bus.MEM_WR    = wr_q;
            bus.MEM_ADDR  = {waddr_q, 2'b00};
            bus.MEM_MASK  = mask_q;
            bus.MEM_WDATA = bus.EXT_WDATA;
        end
    end

    // A BUSY cycle without a beat is by definition one lost to the core.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (state != BUSY || beat) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != STARVE_LIMIT) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rvld_q     <= 1'b0;
            done_q     <= 1'b0;
            starve_q   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            ack_q      <= 1'b0;
            rvld_q     <= beat && !wr_q;
            done_q     <= beat && (cnt_q == 2'd0);
            starve_cnt <= starve_cnt_nxt;
            starve_q   <= (starve_cnt_nxt == STARVE_LIMIT);
            case (state)
                IDLE: begin
                    if (bus.EXT_REQ) begin
                        state   <= BUSY;
                        wr_q    <= bus.EXT_WR;
                        waddr_q <= bus.EXT_ADDR[31:2];
                        mask_q  <= bus.EXT_MASK;
                        cnt_q   <= bus.EXT_LEN;
                        ack_q   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        waddr_q <= waddr_q + 30'd1;
                        cnt_q   <= cnt_q - 2'd1;
                        if (cnt_q == 2'd0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tawas_dbus_arb.sv
// Randomised and directed bench for tawas_dbus_arb, checked every cycle
// against a burst-level behavioural model of the arbiter.
module tb_tawas_dbus_arb;

    localparam logic [3:0] LIMIT = 4'd15;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    tawas_dbus_arb_if bus();

    tawas_dbus_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Burst-level model: byte address, beats still owed, blocked-cycle count.
    bit          m_busy = 0;
    bit          m_first = 0;
    bit          m_rv = 0;
    bit          m_dn = 0;
    bit          m_wr = 0;
    logic [31:0] m_addr = '0;
    logic [3:0]  m_mask = '0;
    int          m_left = 0;
    int          m_blocked = 0;

    int          beat_cyc[$];
    logic [31:0] beat_addr[$];
    int          ack_cyc[$];
    int          done_cyc[$];
    int          starve_cyc[$];
    int          rvld_n = 0;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    logic        e_beat, e_cs, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;

    always @(negedge CLK) begin
        if (!RST_N) begin
            m_busy = 0; m_first = 0; m_rv = 0; m_dn = 0; m_blocked = 0;
        end
        e_beat = m_busy && !bus.CORE_DCS;
        e_cs = 0; e_wr = 0; e_addr = '0; e_mask = '0; e_wdata = '0;
        if (bus.CORE_DCS) begin
            e_cs = 1; e_wr = bus.CORE_DWR; e_addr = bus.CORE_DADDR;
            e_mask = bus.CORE_DMASK; e_wdata = bus.CORE_DOUT;
        end else if (e_beat) begin
            e_cs = 1; e_wr = m_wr; e_addr = m_addr; e_mask = m_mask; e_wdata = bus.EXT_WDATA;
        end
        checkOutput("mem_cs", bus.MEM_CS, e_cs);
        checkOutput("mem_wr", bus.MEM_WR, e_wr);
        checkOutput("mem_addr", bus.MEM_ADDR, e_addr);
        checkOutput("mem_mask", bus.MEM_MASK, e_mask);
        checkOutput("mem_wdata", bus.MEM_WDATA, e_wdata);
        checkOutput("ext_beat", bus.EXT_BEAT, e_beat);
        checkOutput("ext_ack", bus.EXT_ACK, m_first);
        checkOutput("ext_rvld", bus.EXT_RVLD, m_rv);
        checkOutput("ext_done", bus.EXT_DONE, m_dn);
        checkOutput("starve", bus.STARVE, m_blocked >= int'(LIMIT));
        checkOutput("core_din", bus.CORE_DIN, bus.MEM_RDATA);
        if (m_rv) checkOutput("ext_rdata", bus.EXT_RDATA, bus.MEM_RDATA);

        if (bus.EXT_BEAT) begin beat_cyc.push_back(cyc); beat_addr.push_back(bus.MEM_ADDR); end
        if (bus.EXT_ACK) ack_cyc.push_back(cyc);
        if (bus.EXT_DONE) done_cyc.push_back(cyc);
        if (bus.STARVE) starve_cyc.push_back(cyc);
        if (bus.EXT_RVLD) rvld_n++;

        if (RST_N) begin
            m_first = 0;
            m_rv = e_beat && !m_wr;
            m_dn = e_beat && (m_left == 0);
            if (m_busy) begin
                if (e_beat) begin
                    m_blocked = 0;
                    m_addr = m_addr + 32'd4;
                    if (m_left == 0) m_busy = 0;
                    else m_left--;
                end else begin
                    m_blocked++;
                end
            end else begin
                m_blocked = 0;
                if (bus.EXT_REQ) begin
                    m_busy = 1; m_first = 1; m_wr = bus.EXT_WR;
                    m_addr = {bus.EXT_ADDR[31:2], 2'b00};
                    m_mask = bus.EXT_MASK; m_left = int'(bus.EXT_LEN);
                end
            end
        end
    end

    task automatic applyStimulus(input logic dcs, input logic req, input logic wr,
                                 input logic [31:0] addr, input logic [1:0] len);
        @(posedge CLK);
        #1;
        bus.CORE_DCS   = dcs;
        bus.CORE_DWR   = 1'($urandom);
        bus.CORE_DADDR = $urandom;
        bus.CORE_DMASK = 4'($urandom);
        bus.CORE_DOUT  = $urandom;
        bus.MEM_RDATA  = $urandom;
        bus.EXT_WDATA  = $urandom;
        bus.EXT_REQ    = req;
        bus.EXT_WR     = wr;
        bus.EXT_ADDR   = addr;
        bus.EXT_MASK   = 4'($urandom);
        bus.EXT_LEN    = len;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic clearLogs();
        beat_cyc.delete(); beat_addr.delete(); ack_cyc.delete();
        done_cyc.delete(); starve_cyc.delete(); rvld_n = 0;
    endtask

    task automatic checkBeats(input string nm, input int t0, input int first_off,
                              input logic [31:0] base, input int n);
        logic [31:0] a;
        checkOutput({nm, "_nbeats"}, beat_cyc.size(), n);
        a = base;
        for (int i = 0; i < n && i < beat_cyc.size(); i++) begin
            checkOutput({nm, "_beat_cyc"}, beat_cyc[i], t0 + first_off + i);
            checkOutput({nm, "_beat_addr"}, beat_addr[i], a);
            a = a + 32'd4;
        end
    endtask

    int   t;
    bit   req_hold;
    int   req_wait;
    logic r_wr;
    logic [31:0] r_addr;
    logic [1:0]  r_len;
    int   dcs_pct;

    initial begin
        bus.CORE_DCS = 0; bus.CORE_DWR = 0; bus.CORE_DADDR = '0; bus.CORE_DMASK = '0;
        bus.CORE_DOUT = '0; bus.MEM_RDATA = '0; bus.EXT_WDATA = '0; bus.EXT_REQ = 0;
        bus.EXT_WR = 0; bus.EXT_ADDR = '0; bus.EXT_MASK = '0; bus.EXT_LEN = '0;
        RST_N = 0;
        idle(3);
        checkOutput("reset_ack", bus.EXT_ACK, 1'b0);
        checkOutput("reset_starve", bus.STARVE, 1'b0);
        @(posedge CLK); #1; RST_N = 1;
        idle(2);

        $display("[TB] read burst of four at 0x100");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 2'd3); t = cyc;
        idle(7);
        checkOutput("rd4_ack_n", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) checkOutput("rd4_ack_cyc", ack_cyc[0], t + 1);
        checkBeats("rd4", t, 1, 32'h100, 4);
        checkOutput("rd4_rvld_n", rvld_n, 4);
        checkOutput("rd4_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) checkOutput("rd4_done_cyc", done_cyc[0], t + 5);

        $display("[TB] write burst of two at 0x200 behind core traffic");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 2'd1); t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        idle(6);
        checkBeats("wr2", t, 3, 32'h200, 2);
        checkOutput("wr2_rvld_n", rvld_n, 0);
        checkOutput("wr2_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) checkOutput("wr2_done_cyc", done_cyc[0], t + 5);

        $display("[TB] read burst wrapping the top of the address space");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 2'd1); t = cyc;
        idle(5);
        checkBeats("wrap", t, 1, 32'hFFFF_FFFC, 2);
        if (beat_addr.size() > 1) checkOutput("wrap_zero", beat_addr[1], 32'h0);

        $display("[TB] twenty blocked cycles");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 2'd0); t = cyc;
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        idle(5);
        checkBeats("starve", t, 21, 32'h40, 1);
        checkOutput("starve_len", starve_cyc.size(), 6);
        if (starve_cyc.size() > 0) begin
            checkOutput("starve_rise", starve_cyc[0], t + 16);
            checkOutput("starve_fall", starve_cyc[$], t + 21);
        end

        $display("[TB] reset in the middle of a burst");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 2'd3); t = cyc;
        idle(2);
        @(posedge CLK); #1; RST_N = 0;
        idle(1);
        @(posedge CLK); #1; RST_N = 1;
        idle(6);
        checkBeats("rst", t, 1, 32'h300, 2);
        checkOutput("rst_rvld_n", rvld_n, 1);
        checkOutput("rst_done_n", done_cyc.size(), 0);
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h500, 2'd0); t = cyc;
        idle(3);
        checkBeats("rerq", t, 1, 32'h500, 1);

        $display("[TB] request and core access in the same idle cycle");
        clearLogs();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h600, 2'd0); t = cyc;
        bus.CORE_DADDR = 32'h0000_ABC0;
        #1;
        checkOutput("same_core_addr", bus.MEM_ADDR, 32'h0000_ABC0);
        checkOutput("same_core_cs", bus.MEM_CS, 1'b1);
        idle(4);
        checkOutput("same_ack_n", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) checkOutput("same_ack_cyc", ack_cyc[0], t + 1);
        checkBeats("same", t, 1, 32'h600, 1);

        $display("[TB] randomised traffic");
        req_hold = 0; req_wait = 0; r_wr = 0; r_addr = '0; r_len = '0; dcs_pct = 45;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) dcs_pct = (i % 300 == 0) ? 95 : ((i % 200 == 0) ? 10 : 45);
            if (!req_hold && $urandom_range(0, 5) == 0) begin
                req_hold = 1; req_wait = 0;
                r_wr = 1'($urandom); r_addr = $urandom; r_len = 2'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                @(posedge CLK); #1; RST_N = 0;
                idle(1);
                @(posedge CLK); #1; RST_N = 1;
                req_hold = 0;
            end
            applyStimulus(1'($urandom_range(0, 99) < dcs_pct), req_hold, r_wr, r_addr, r_len);
            if (req_hold) begin
                if (bus.EXT_ACK) begin
                    req_hold = 0;
                end else if (++req_wait > 200) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL ack_timeout at cycle %0d: got no ack, expected one within 200 cycles", cyc);
                    req_hold = 0;
                end
            end
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
